inwrapper_collect: RTL and testbench
====================================

Name: inwrapper_collect

Overview:
- Input-side wrapper for the FP datapath, sitting upstream of the FP unit; it mirrors the output wrapper that presents results.
- Accepts operand data from the upstream producer over a narrow word bus using a ready/accept handshake.
- Assembles two double-width operands from the received words, pulses a start to the FP unit, then holds off new input until the FP unit reports done.
- Handshake polarity matches the result side: the producer asserts inReady with data, and this block answers with inAccept.

Parameters:
- W, 16, width of one input word on inData.
- OPW, 2*W, width of each assembled operand (fixed at 2*W; not independently settable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- inReady  input  1  upstream has a valid word on inData.
- inData  input  W  operand word; order is A-lo, A-hi, B-lo, B-hi.
- inAccept  output  1  block can take a word this cycle.
- doneFP  input  1  FP unit finished the current operation (one-cycle pulse or level).
- startFP  output  1  one-cycle start pulse to the FP unit.
- opA  output  OPW  operand A, registered.
- opB  output  OPW  operand B, registered.
- busy  output  1  high from the start pulse until doneFP is taken.
- beatCnt  output  2  index of the next word expected (0..3), for debug.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Asserting rst at any time forces:
  - state=Collect, beatCnt=0.
  - opA=0, opB=0, startFP=0, busy=0.
  - inAccept=0 while rst is high.
- States: Collect, Start, Wait.
- Collect:
  - inAccept=1 (Moore, decoded from the state).
  - A transfer occurs at a posedge where inReady=1 and inAccept=1.
  - On a transfer, inData is written to the slot selected by beatCnt: 0->opA[W-1:0], 1->opA[OPW-1:W], 2->opB[W-1:0], 3->opB[OPW-1:W].
  - beatCnt then increments, wrapping 3->0.
  - The transfer with beatCnt=3 moves the state to Start.
  - With inReady=0 there is no write and no count change; a gap of any length between beats is legal.
- Start:
  - startFP=1 and busy=1 for exactly this one cycle; inAccept=0.
  - Next state is Wait unconditionally.
  - doneFP is ignored in Start.
- Wait:
  - busy=1, inAccept=0, startFP=0.
  - On doneFP=1 the next state is Collect; otherwise stay in Wait.
- Operand stability: opA and opB stay stable from the end of Collect until the next transfer. They are never cleared between operations.
- Latency: the last beat is accepted at edge N; startFP is high during cycle N+1. doneFP seen at edge M returns the block to Collect, so inAccept=1 in cycle M+1.
- Simultaneous events:
  - inReady during Start or Wait: no transfer, because inAccept=0. The producer must hold the word.
  - doneFP during Collect: ignored.
- Reset mid-collect: already-received beats are discarded; the next operation restarts at beat 0.
- No combinational path from inReady or doneFP to any output.

Test Plan:
- Reset check: assert rst asynchronously between edges -> opA, opB, startFP, busy and inAccept drop immediately; after release, inAccept=1 and beatCnt=0.
- Back-to-back beats 0x1111, 0x2222, 0x3333, 0x4444 with inReady held high -> opA=0x22221111, opB=0x44443333; startFP high for one cycle exactly one cycle after the 4th accept; busy=1.
- Gapped beats: inReady toggled 1,0,0,1,0,1,1 -> only cycles with inReady=1 advance beatCnt (0->1->2->3->Start); operands are correct.
- Wait hold: in Wait, hold inReady=1 with data 0xDEAD for 10 cycles, doneFP=0 -> inAccept=0, no operand change; pulse doneFP -> inAccept=1 next cycle and 0xDEAD is taken as A-lo.
- doneFP edge cases: doneFP=1 in the Start cycle -> ignored, block still enters Wait. doneFP=1 during Collect -> no effect on beatCnt or state.
- Reset after 2 beats, then a full new 4-beat sequence 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD -> opA=0xBBBBAAAA, opB=0xDDDDCCCC, and exactly one startFP pulse.

Source files
------------

// File: rtl/inwrapper_collect.sv
// inwrapper_collect: input-side wrapper for the FP datapath.
// Collects four W-bit words (A-lo, A-hi, B-lo, B-hi) into two 2W-bit
// operands, pulses startFP for one cycle, then blocks input until doneFP.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting words; beatCnt selects the operand slot to fill
// START   | one-cycle start pulse to the FP unit; input blocked
// WAIT    | FP unit busy; input blocked until doneFP
module inwrapper_collect #(
    parameter  int W   = 16,
    localparam int OPW = 2 * W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inReady,
    input  logic [W-1:0]   inData,
    output logic           inAccept,
    input  logic           doneFP,
    output logic           startFP,
    output logic [OPW-1:0] opA,
    output logic [OPW-1:0] opB,
    output logic           busy,
    output logic [1:0]     beatCnt
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [1:0]     beat_q,  beat_d;
    logic [OPW-1:0] opa_q,   opa_d;
    logic [OPW-1:0] opb_q,   opb_d;
    logic           xfer;

    // A word moves only while collecting; inReady never reaches an output
    // combinationally because it is only used to compute next state.
    assign xfer = inReady && (state_q == ST_COLLECT);

    // Next-state, beat counter and operand slot writes.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            ST_COLLECT: begin
                if (xfer) begin
                    case (beat_q)
                        2'd0: opa_d[W-1:0]   = inData;
                        2'd1: opa_d[OPW-1:W] = inData;
                        2'd2: opb_d[W-1:0]   = inData;
                        2'd3: opb_d[OPW-1:W] = inData;
                    endcase
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (doneFP) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State, counter and operand registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            beat_q  <= 2'd0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Moore outputs decoded from state; inAccept is also held low while
    // rst is asserted because the reset state itself is COLLECT.
    always_comb begin
        inAccept = (state_q == ST_COLLECT) && !rst;
        startFP  = (state_q == ST_START);
        busy     = (state_q == ST_START) || (state_q == ST_WAIT);
        opA      = opa_q;
        opB      = opb_q;
        beatCnt  = beat_q;
    end

endmodule

// File: tb/tb_inwrapper_collect.sv
// Directed bench for inwrapper_collect with an operand scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_inwrapper_collect;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inReady = 1'b0;
    logic [W-1:0]  inData = '0;
    logic          inAccept;
    logic          doneFP = 1'b0;
    logic          startFP;
    logic [31:0]   opA;
    logic [31:0]   opB;
    logic          busy;
    logic [1:0]    beatCnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    logic [63:0] sb_q[$];

    inwrapper_collect #(.W(W)) dut (
        .clk(clk), .rst(rst), .inReady(inReady), .inData(inData),
        .inAccept(inAccept), .doneFP(doneFP), .startFP(startFP),
        .opA(opA), .opB(opB), .busy(busy), .beatCnt(beatCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every start pulse must match the next expected operand pair.
    always @(negedge clk) begin
        if (!rst && startFP) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_start", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("sb_opA", opA, e[63:32]);
                check("sb_opB", opB, e[31:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send4(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        sb_q.push_back({w1, w0, w3, w2});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inReady = 1'b1;
            inData  = w[i];
        end
        @(negedge clk);
        inReady = 1'b0;
    endtask

    initial begin
        logic       pat [7];
        logic [15:0] gw [4];
        logic [1:0] exp_bc;
        int         wi;
        int         p0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_inAccept", 32'(inAccept), 32'd0);
        check("rst_startFP", 32'(startFP), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_opA", opA, 32'h0);
        check("rst_beatCnt", 32'(beatCnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_inAccept", 32'(inAccept), 32'd1);
        check("rel_beatCnt", 32'(beatCnt), 32'd0);

        // Back-to-back beats; doneFP raised in the Start cycle must be ignored
        send4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("b2b_startFP", 32'(startFP), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_inAccept", 32'(inAccept), 32'd0);
        check("b2b_beatCnt", 32'(beatCnt), 32'd0);
        doneFP = 1'b1;
        @(negedge clk);
        doneFP = 1'b0;
        check("start_done_startFP", 32'(startFP), 32'd0);
        check("start_done_busy", 32'(busy), 32'd1);
        check("start_done_inAccept", 32'(inAccept), 32'd0);
        @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);

        // Asynchronous reset between edges while in Wait
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_opA", opA, 32'h0);
        check("async_opB", opB, 32'h0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_inAccept", 32'(inAccept), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rel_inAccept", 32'(inAccept), 32'd1);
        check("async_rel_beatCnt", 32'(beatCnt), 32'd0);

        // Gapped beats; doneFP pulsed during Collect gaps has no effect
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        gw  = '{16'h0A01, 16'h0A02, 16'h0B01, 16'h0B02};
        sb_q.push_back({32'h0A020A01, 32'h0B020B01});
        exp_bc = 2'd0;
        wi = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("gap_beatCnt", 32'(beatCnt), 32'(exp_bc));
                check("gap_inAccept", 32'(inAccept), 32'd1);
            end
            inReady = pat[i];
            doneFP  = !pat[i];
            if (pat[i]) begin
                inData = gw[wi];
                wi++;
                exp_bc = exp_bc + 2'd1;
            end
        end
        @(negedge clk);
        inReady = 1'b0;
        doneFP  = 1'b0;
        check("gap_startFP", 32'(startFP), 32'd1);
        check("gap_beatCnt_end", 32'(beatCnt), 32'd0);

        // Wait hold: producer holds 0xDEAD while the FP unit is busy
        inReady = 1'b1;
        inData  = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_inAccept", 32'(inAccept), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        check("hold_opA", opA, 32'h0A020A01);
        check("hold_opB", opB, 32'h0B020B01);
        doneFP = 1'b1;
        @(negedge clk);
        doneFP = 1'b0;
        check("done_inAccept", 32'(inAccept), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        sb_q.push_back({32'hBEEFDEAD, 32'h56781234});
        @(negedge clk);
        check("dead_beatCnt", 32'(beatCnt), 32'd1);
        check("dead_opA", opA, 32'h0A02DEAD);
        inData = 16'hBEEF;
        @(negedge clk);
        inData = 16'h1234;
        @(negedge clk);
        inData = 16'h5678;
        @(negedge clk);
        inReady = 1'b0;
        check("dead_startFP", 32'(startFP), 32'd1);
        @(negedge clk);
        doneFP = 1'b1;
        @(negedge clk);
        doneFP = 1'b0;
        check("dead_done_inAccept", 32'(inAccept), 32'd1);

        // Reset after two beats discards them; new full sequence
        inReady = 1'b1;
        inData  = 16'h5555;
        @(negedge clk);
        inData  = 16'h6666;
        @(negedge clk);
        inReady = 1'b0;
        check("part_beatCnt", 32'(beatCnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("part_rst_beatCnt", 32'(beatCnt), 32'd0);
        check("part_rst_opA", opA, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        p0 = pulse_cnt;
        send4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        check("new_startFP", 32'(startFP), 32'd1);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("new_opA", opA, 32'hBBBBAAAA);
        check("new_opB", opB, 32'hDDDDCCCC);
        check("new_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("new_busy", 32'(busy), 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
